// File: rtl/uart_serial_tx_pkg.sv
// Shared types and line-level constants for the UART transmitter.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    localparam logic LINE_IDLE = 1'b1;
    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;

endpackage

// File: rtl/uart_serial_tx_if.sv
// Valid/ready word handshake feeding the UART transmitter.
interface uart_serial_tx_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] data;
    logic             valid;
    logic             ready;

    modport master (output data, output valid, input ready);
    modport slave  (input data, input valid, output ready);
endinterface

// File: rtl/uart_serial_tx_bit_timer.sv
// Bit-period timer: tick marks the last cycle of each serial bit.
module bit_timer #(
    parameter int CLKS_PER_BIT = 4
) (
    input  logic hz100,
    input  logic reset,
    input  logic clear,
    output logic tick
);
    localparam int CW = $clog2(CLKS_PER_BIT + 1);

    logic [CW-1:0] r_cnt;

    assign tick = !clear && (r_cnt == CW'(CLKS_PER_BIT - 1));

    always_ff @(posedge hz100 or posedge reset) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (clear || tick) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end
endmodule

// File: rtl/uart_serial_tx.sv
// Parallel-to-serial UART frame transmitter, LSB first.
// Define PARITY_EN to insert an even-parity bit before the stop bit.
module uart_serial_tx
    import uart_pkg::*;
#(
    parameter int WIDTH        = 8,
    parameter int CLKS_PER_BIT = 4
) (
    input  logic             hz100,
    input  logic             reset,
    uart_serial_tx_if.slave  bus,
    output logic             tx,
    output logic             busy
);
    localparam int IW = $clog2(WIDTH + 1);

    state_t           r_state;
    logic [WIDTH-1:0] r_shreg;
    logic [IW-1:0]    r_idx;
    logic             r_tx;
    logic             r_busy;
    logic             r_ready;
    logic             w_tick;
    logic             w_clear;
`ifdef PARITY_EN
    logic             r_par;
`endif

    // Timer is held at zero in IDLE, so START always gets a full period.
    assign w_clear   = (r_state == IDLE);
    assign tx        = r_tx;
    assign busy      = r_busy;
    assign bus.ready = r_ready;

    bit_timer #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_timer (
        .hz100 (hz100),
        .reset (reset),
        .clear (w_clear),
        .tick  (w_tick)
    );

    always_ff @(posedge hz100 or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
            r_shreg <= '0;
            r_idx   <= '0;
            r_tx    <= LINE_IDLE;
            r_busy  <= 1'b0;
            r_ready <= 1'b1;
`ifdef PARITY_EN
            r_par   <= 1'b0;
`endif
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (bus.valid && r_ready) begin
                        r_shreg <= bus.data;
                        r_idx   <= '0;
                        r_state <= START;
                        r_tx    <= START_BIT;
                        r_busy  <= 1'b1;
                        r_ready <= 1'b0;
`ifdef PARITY_EN
                        r_par   <= ^bus.data;
`endif
                    end
                end
                START: begin
                    if (w_tick) begin
                        r_state <= DATA;
                        r_tx    <= r_shreg[0];
                    end
                end
                DATA: begin
                    if (w_tick) begin
                        if (r_idx == IW'(WIDTH - 1)) begin
                            r_idx <= '0;
`ifdef PARITY_EN
                            r_state <= PARITY;
                            r_tx    <= r_par;
`else
                            r_state <= STOP;
                            r_tx    <= STOP_BIT;
`endif
                        end else begin
                            r_shreg <= r_shreg >> 1;
                            r_idx   <= r_idx + 1'b1;
                            r_tx    <= r_shreg[1];
                        end
                    end
                end
`ifdef PARITY_EN
                PARITY: begin
                    if (w_tick) begin
                        r_state <= STOP;
                        r_tx    <= STOP_BIT;
                    end
                end
`endif
                STOP: begin
                    if (w_tick) begin
                        r_state <= IDLE;
                        r_tx    <= LINE_IDLE;
                        r_busy  <= 1'b0;
                        r_ready <= 1'b1;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_tx    <= LINE_IDLE;
                    r_busy  <= 1'b0;
                    r_ready <= 1'b1;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_uart_serial_tx.sv
// Bench for uart_serial_tx: queue model plus directed literal frames.
module tb_uart_serial_tx;

    localparam int NP =
`ifdef PARITY_EN
        11;
`else
        10;
`endif
    localparam int F0 = NP * 4;

`ifdef PARITY_EN
    localparam logic [10:0] P_A5 = 11'b10101001010;
    localparam logic [10:0] P_07 = 11'b11000001110;
    localparam logic [10:0] P_3C = 11'b10001111000;
`else
    localparam logic [10:0] P_A5 = 11'b01101001010;
    localparam logic [10:0] P_07 = 11'b01000001110;
    localparam logic [10:0] P_3C = 11'b01001111000;
`endif

    logic hz100 = 1'b0;
    logic reset = 1'b1;
    logic tx0, tx1, busy0, busy1;
    int   checks = 0;
    int   errors = 0;

    uart_serial_tx_if #(.WIDTH(8)) if0 ();
    uart_serial_tx_if #(.WIDTH(8)) if1 ();

    uart_serial_tx #(.WIDTH(8), .CLKS_PER_BIT(4)) u0 (
        .hz100 (hz100), .reset (reset), .bus (if0.slave),
        .tx (tx0), .busy (busy0)
    );
    uart_serial_tx #(.WIDTH(8), .CLKS_PER_BIT(1)) u1 (
        .hz100 (hz100), .reset (reset), .bus (if1.slave),
        .tx (tx1), .busy (busy1)
    );

    always #5 hz100 = ~hz100;

    task automatic chk(input string nm, input logic a, input logic e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s t=%0t got %b want %b", nm, $time, a, e);
        end
    endtask

    // Value on the line during bit period k of a frame carrying d.
    function automatic bit frame_bit(input logic [7:0] d, input int k);
        if (k == 0) return 1'b0;
        if (k <= 8) return d[k-1];
        if (k == 9 && NP == 11) return ^d;
        return 1'b1;
    endfunction

    bit q0[$];
    bit q1[$];

    always @(posedge hz100 or posedge reset) begin
        if (reset) begin
            q0.delete();
            q1.delete();
        end else begin
            if (q0.size() != 0) void'(q0.pop_front());
            else if (if0.valid)
                for (int k = 0; k < NP * 4; k++) q0.push_back(frame_bit(if0.data, k / 4));
            if (q1.size() != 0) void'(q1.pop_front());
            else if (if1.valid)
                for (int k = 0; k < NP; k++) q1.push_back(frame_bit(if1.data, k));
        end
    end

    always @(negedge hz100) begin
        chk("m_tx0", tx0, q0.size() != 0 ? q0[0] : 1'b1);
        chk("m_rdy0", if0.ready, q0.size() == 0);
        chk("m_busy0", busy0, q0.size() != 0);
        chk("m_tx1", tx1, q1.size() != 0 ? q1[0] : 1'b1);
        chk("m_rdy1", if1.ready, q1.size() == 0);
        chk("m_busy1", busy1, q1.size() != 0);
    end

    function automatic logic get_tx(input int i);
        return i == 0 ? tx0 : tx1;
    endfunction
    function automatic logic get_rdy(input int i);
        return i == 0 ? if0.ready : if1.ready;
    endfunction
    function automatic logic get_busy(input int i);
        return i == 0 ? busy0 : busy1;
    endfunction

    task automatic set_in(input int i, input logic v, input logic [7:0] d);
        if (i == 0) begin
            if0.valid = v;
            if0.data  = d;
        end else begin
            if1.valid = v;
            if1.data  = d;
        end
    endtask

    task automatic wait_ready(input int i);
        int n = 0;
        @(negedge hz100);
        while (!get_rdy(i) && n < 200) begin
            @(negedge hz100);
            n++;
        end
        if (n >= 200) chk("ready_timeout", 1'b0, 1'b1);
    endtask

    task automatic frame(input int i, input logic [7:0] d,
                         input logic [10:0] pat, input string nm);
        int cpb = (i == 0) ? 4 : 1;
        wait_ready(i);
        set_in(i, 1'b1, d);
        @(posedge hz100);
        @(negedge hz100);
        set_in(i, 1'b0, d);
        for (int n = 1; n <= NP * cpb; n++) begin
            chk({nm, "_tx"}, get_tx(i), pat[(n-1)/cpb]);
            if (n < NP * cpb) @(negedge hz100);
        end
        @(negedge hz100);
        chk({nm, "_rdy"}, get_rdy(i), 1'b1);
        chk({nm, "_busy"}, get_busy(i), 1'b0);
    endtask

    initial begin
        set_in(0, 1'b0, 8'h00);
        set_in(1, 1'b0, 8'h00);
        repeat (2) @(negedge hz100);
        chk("rst_tx", tx0, 1'b1);
        chk("rst_rdy", if0.ready, 1'b1);
        chk("rst_busy", busy0, 1'b0);
        #1 reset = 1'b0;
        repeat (3) @(negedge hz100);
        chk("idle_tx", tx0, 1'b1);

        frame(0, 8'hA5, P_A5, "a5");
        frame(0, 8'h07, P_07, "p07");
        frame(1, 8'h3C, P_3C, "c1_3c");
        frame(1, 8'hA5, P_A5, "c1_a5");

        wait_ready(0);
        set_in(0, 1'b1, 8'h01);
        @(posedge hz100);
        for (int n = 1; n <= F0 + 1; n++) begin
            @(negedge hz100);
            if (n == 1) set_in(0, 1'b1, 8'h80);
        end
        chk("b2b_gap_tx", tx0, 1'b1);
        chk("b2b_gap_rdy", if0.ready, 1'b1);
        @(negedge hz100);
        chk("b2b_start_tx", tx0, 1'b0);
        chk("b2b_start_busy", busy0, 1'b1);
        set_in(0, 1'b0, 8'h80);

        wait_ready(0);
        set_in(0, 1'b1, 8'h00);
        @(posedge hz100);
        for (int n = 1; n <= F0; n++) begin
            @(negedge hz100);
            if (n == 1) set_in(0, 1'b0, 8'h00);
            if (n == 10) set_in(0, 1'b1, 8'hFF);
            if (n == 11) set_in(0, 1'b0, 8'hFF);
            if (n >= 5 && n <= 36) chk("ign_data", tx0, 1'b0);
        end
        for (int n = 0; n < 6; n++) begin
            @(negedge hz100);
            chk("ign_idle_tx", tx0, 1'b1);
            chk("ign_idle_busy", busy0, 1'b0);
        end

        wait_ready(0);
        set_in(0, 1'b1, 8'hA5);
        @(posedge hz100);
        @(negedge hz100);
        set_in(0, 1'b0, 8'hA5);
        @(negedge hz100);
        chk("mid_tx_pre", tx0, 1'b0);
        #2 reset = 1'b1;
        #1;
        chk("mid_rst_tx", tx0, 1'b1);
        chk("mid_rst_rdy", if0.ready, 1'b1);
        chk("mid_rst_busy", busy0, 1'b0);
        repeat (2) @(negedge hz100);
        #1 reset = 1'b0;
        for (int n = 0; n < 8; n++) begin
            @(negedge hz100);
            chk("post_rst_tx", tx0, 1'b1);
            chk("post_rst_rdy", if0.ready, 1'b1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
